mux_2to1: RTL and testbench
===========================

Name: mux_2to1

Overview:
Parameterised 2-to-1 selector for the 32-bit pipelined MIPS datapath. Typical uses are the RegDst (5-bit register index), ALUSrc and MemToReg (32-bit) selections. The primary output is purely combinational. A registered shadow copy plus select-change tracking give pipeline stages and the debug/trace logic a cycle-aligned view.

Parameters:
- WIDTH, 32, bit width of both data inputs and of every data output; legal range 1..64.
- RESET_VAL, 0, value loaded into registered outputs on reset; truncated to WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- inp1  input  WIDTH  data selected when select=0
- inp2  input  WIDTH  data selected when select=1
- select  input  1  selection control
- result  output  WIDTH  selected data, combinational (see Optional Feature)
- result_q  output  WIDTH  result registered on clk
- sel_q  output  1  select registered on clk
- sel_changed  output  1  high for one cycle when the registered select differs from its previous registered value

Interface note: one clock; reset is synchronous and active-high. Ports are named clk and rst.

Behaviour:
- result = select ? inp2 : inp1, zero-delay combinational. It must not depend on clk or rst.
- select X/Z (simulation only): result is all-X. Synthesis ignores this case.
- Narrower connected buses are truncated to the low WIDTH bits by port connection. Example: WIDTH=5 with 32-bit buses gives the low 5 bits, upper bits undriven/zero at the parent.
- On a rising clk edge with rst=1:
  - result_q <= RESET_VAL[WIDTH-1:0]
  - sel_q <= 0
  - sel_changed <= 0
- On a rising clk edge with rst=0:
  - result_q <= combinational selection
  - sel_q <= select
  - sel_changed <= (select != sel_q)
- Latency: result 0 cycles; result_q, sel_q and sel_changed 1 cycle.
- Reset asserted mid-operation: registered outputs clear on the next edge. result keeps tracking the inputs during reset.
- Simultaneous data and select change: result reflects both in the same delta. result_q captures the post-change values at the next edge.
- The first cycle after reset release with select=1 asserts sel_changed, because sel_q was reset to 0.
- No X must leave the registered outputs after reset when the inputs are known.

Optional Feature:
- Macro MUX_REG_OUT_EN.
- Defined: result is driven from result_q (1-cycle latency) and the combinational path is removed. Used for timing closure at stage boundaries.
- Undefined (default): result is combinational as above. result_q is still present.

Decomposition:
- Shared package mux_pkg holds:
  - constant MUX_SEL_IN1 = 1'b0 and MUX_SEL_IN2 = 1'b1
  - DEFAULT_WIDTH = 32 and REGIDX_WIDTH = 5, the latter used for RegDst instances
- Optional sub-module mux_out_reg: a WIDTH-bit register with sync reset. It holds result_q and is reused for sel_q at width 1.
- The top level contains the selection logic and the change-detect logic.

Test Plan:
- WIDTH=5, inp1=2, inp2=3, select=0 -> result=2 immediately. At 100 ns, select=1 -> result=3 within the same timestep.
- WIDTH=32, inp1=32'hDEAD_BEEF, inp2=32'h1234_5678, toggle select each cycle -> result alternates combinationally; result_q lags by exactly one clk edge.
- rst=1 for 2 cycles with RESET_VAL=7 and select=1 -> result_q=7, sel_q=0, sel_changed=0. First edge after release -> result_q=inp2, sel_changed=1.
- Hold select=1 for 3 cycles after a 0 -> sel_changed high for exactly one cycle, then 0.
- Assert rst mid-stream while inputs keep changing -> result still follows the inputs; registered outputs clear on the next edge.
- Build with MUX_REG_OUT_EN defined and rerun scenario 2 -> result equals result_q (1-cycle latency).

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the datapath 2-to-1 selectors (select encodings and the
// standard widths used by RegDst and 32-bit data instances).
package mux_pkg;

   localparam logic MUX_SEL_IN1 = 1'b0;
   localparam logic MUX_SEL_IN2 = 1'b1;

   localparam int DEFAULT_WIDTH = 32;
   localparam int REGIDX_WIDTH  = 5;

endpackage

// File: rtl/mux_out_reg.sv
// WIDTH-bit register with synchronous active-high reset; holds the registered
// copy of the selector output and, at width 1, the registered select.
module mux_out_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mux_2to1.sv
// Parameterised 2-to-1 selector with registered shadow output and select-change flag.
// Define MUX_REG_OUT_EN to drive result from the registered copy (1-cycle latency).
module mux_2to1
   import mux_pkg::*;
#(
   parameter int          WIDTH     = DEFAULT_WIDTH,
   parameter logic [63:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   input  logic             select,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_q,
   output logic             sel_q,
   output logic             sel_changed
);

   logic [WIDTH-1:0] sel_data;

   // An unknown select propagates as all-X in simulation; synthesis treats it as don't-care.
   always_comb begin
      sel_data = 'x;
      case (select)
         MUX_SEL_IN1: sel_data = inp1;
         MUX_SEL_IN2: sel_data = inp2;
         default:     sel_data = 'x;
      endcase
   end

   mux_out_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL[WIDTH-1:0])
   ) u_result_reg (
      .clk (clk),
      .rst (rst),
      .d   (sel_data),
      .q   (result_q)
   );

   mux_out_reg #(
      .WIDTH     (1),
      .RESET_VAL (MUX_SEL_IN1)
   ) u_sel_reg (
      .clk (clk),
      .rst (rst),
      .d   (select),
      .q   (sel_q)
   );

   // Compared against the pre-edge sel_q, so the flag lines up with the new sel_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_changed <= 1'b0;
      end else begin
         sel_changed <= (select != sel_q);
      end
   end

`ifdef MUX_REG_OUT_EN
   assign result = result_q;
`else
   assign result = sel_data;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed, table-driven bench for mux_2to1: a 32-bit instance (RESET_VAL=7) and a
// 5-bit RegDst-style instance share clock, reset and select.
module tb_mux_2to1;
   import mux_pkg::*;

   typedef struct {
      logic        sel;
      logic [31:0] a32;
      logic [31:0] b32;
      logic [4:0]  a5;
      logic [4:0]  b5;
      logic [31:0] exp32;
      logic [4:0]  exp5;
      logic        exp_chg;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        select;
   logic [31:0] inp1_32, inp2_32, result_32, result_q_32;
   logic [4:0]  inp1_5, inp2_5, result_5, result_q_5;
   logic        sel_q_32, sel_changed_32, sel_q_5, sel_changed_5;

   int checks = 0;
   int errors = 0;

   vec_t vecs[9];

   always #5 clk = ~clk;

   mux_2to1 #(.WIDTH(32), .RESET_VAL(64'd7)) dut32 (
      .clk         (clk),
      .rst         (rst),
      .inp1        (inp1_32),
      .inp2        (inp2_32),
      .select      (select),
      .result      (result_32),
      .result_q    (result_q_32),
      .sel_q       (sel_q_32),
      .sel_changed (sel_changed_32)
   );

   mux_2to1 #(.WIDTH(REGIDX_WIDTH)) dut5 (
      .clk         (clk),
      .rst         (rst),
      .inp1        (inp1_5),
      .inp2        (inp2_5),
      .select      (select),
      .result      (result_5),
      .result_q    (result_q_5),
      .sel_q       (sel_q_5),
      .sel_changed (sel_changed_5)
   );

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic s, input logic [31:0] a32, input logic [31:0] b32,
                                 input logic [4:0] a5, input logic [4:0] b5);
      select  = s;
      inp1_32 = a32;
      inp2_32 = b32;
      inp1_5  = a5;
      inp2_5  = b5;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2,  5'd3,  32'hDEAD_BEEF, 5'd2,  1'b1};
      vecs[1] = '{1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2,  5'd3,  32'h1234_5678, 5'd3,  1'b1};
      vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2,  5'd3,  32'hDEAD_BEEF, 5'd2,  1'b1};
      vecs[3] = '{1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2,  5'd3,  32'h1234_5678, 5'd3,  1'b1};
      vecs[4] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 5'h1F, 5'h00, 32'h0000_0000, 5'h1F, 1'b1};
      vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 5'h00, 5'h1F, 32'hFFFF_FFFF, 5'h00, 1'b0};
      vecs[6] = '{1'b1, 32'hAAAA_5555, 32'h5555_AAAA, 5'h15, 5'h0A, 32'h5555_AAAA, 5'h0A, 1'b1};
      vecs[7] = '{1'b1, 32'hAAAA_5555, 32'h0000_0001, 5'h15, 5'h01, 32'h0000_0001, 5'h01, 1'b0};
      vecs[8] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 5'h00, 5'h10, 32'h8000_0000, 5'h10, 1'b0};

      // Reset held for two edges with select=1.
      rst = 1'b1;
      apply_stimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2, 5'd3);
      tick();
      tick();
      check_output("rst_result_q32", 64'(result_q_32), 64'd7);
      check_output("rst_sel_q32", 64'(sel_q_32), 64'd0);
      check_output("rst_sel_changed32", 64'(sel_changed_32), 64'd0);
      check_output("rst_result_q5", 64'(result_q_5), 64'd0);
      check_output("rst_sel_q5", 64'(sel_q_5), 64'd0);
`ifndef MUX_REG_OUT_EN
      check_output("rst_comb_result32", 64'(result_32), 64'h1234_5678);
      check_output("rst_comb_result5", 64'(result_5), 64'd3);
`else
      check_output("rst_reg_result32", 64'(result_32), 64'd7);
`endif

      // First edge after release with select=1 flags a change from the reset sel_q.
      rst = 1'b0;
      tick();
      check_output("rel_result_q32", 64'(result_q_32), 64'h1234_5678);
      check_output("rel_sel_q32", 64'(sel_q_32), 64'd1);
      check_output("rel_sel_changed32", 64'(sel_changed_32), 64'd1);
      check_output("rel_sel_changed5", 64'(sel_changed_5), 64'd1);
      tick();
      check_output("rel_sel_changed32_2", 64'(sel_changed_32), 64'd0);

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].sel, vecs[i].a32, vecs[i].b32, vecs[i].a5, vecs[i].b5);
         #1;
`ifndef MUX_REG_OUT_EN
         check_output($sformatf("vec%0d_result32", i), 64'(result_32), 64'(vecs[i].exp32));
         check_output($sformatf("vec%0d_result5", i), 64'(result_5), 64'(vecs[i].exp5));
`endif
         tick();
         check_output($sformatf("vec%0d_result_q32", i), 64'(result_q_32), 64'(vecs[i].exp32));
         check_output($sformatf("vec%0d_result_q5", i), 64'(result_q_5), 64'(vecs[i].exp5));
         check_output($sformatf("vec%0d_sel_q", i), 64'(sel_q_32), 64'(vecs[i].sel));
         check_output($sformatf("vec%0d_sel_changed", i), 64'(sel_changed_32), 64'(vecs[i].exp_chg));
`ifdef MUX_REG_OUT_EN
         check_output($sformatf("vec%0d_reg_result32", i), 64'(result_32), 64'(vecs[i].exp32));
`endif
      end

      // Select held at 1 for three edges after settling at 0.
      apply_stimulus(1'b0, 32'h0000_1111, 32'h0000_2222, 5'd4, 5'd9);
      tick();
      tick();
      check_output("hold_pre_sel_changed", 64'(sel_changed_32), 64'd0);
      select = 1'b1;
      tick();
      check_output("hold_c1_sel_changed", 64'(sel_changed_32), 64'd1);
      check_output("hold_c1_result_q32", 64'(result_q_32), 64'h0000_2222);
      tick();
      check_output("hold_c2_sel_changed", 64'(sel_changed_32), 64'd0);
      tick();
      check_output("hold_c3_sel_changed", 64'(sel_changed_32), 64'd0);
      check_output("hold_c3_sel_q", 64'(sel_q_32), 64'd1);

      // Reset asserted mid-stream while the inputs keep moving.
      rst = 1'b1;
      apply_stimulus(1'b1, 32'hCAFE_0000, 32'h0BAD_F00D, 5'd7, 5'd12);
      #1;
`ifndef MUX_REG_OUT_EN
      check_output("mid_comb_result32_a", 64'(result_32), 64'h0BAD_F00D);
`endif
      tick();
      check_output("mid_result_q32", 64'(result_q_32), 64'd7);
      check_output("mid_result_q5", 64'(result_q_5), 64'd0);
      check_output("mid_sel_q", 64'(sel_q_32), 64'd0);
      check_output("mid_sel_changed", 64'(sel_changed_32), 64'd0);
      apply_stimulus(1'b0, 32'h7777_8888, 32'h9999_AAAA, 5'd17, 5'd30);
      #1;
`ifndef MUX_REG_OUT_EN
      check_output("mid_comb_result32_b", 64'(result_32), 64'h7777_8888);
      check_output("mid_comb_result5_b", 64'(result_5), 64'd17);
`endif
      tick();
      rst = 1'b0;
      tick();
      check_output("post_mid_result_q32", 64'(result_q_32), 64'h7777_8888);
      check_output("post_mid_sel_changed", 64'(sel_changed_32), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
